// File: rtl/compositor_pkg.sv
// Shared types and elaboration helpers for the layer compositor and its fade controller.
package compositor_pkg;

  localparam int unsigned RGB_W              = 24;
  localparam int unsigned TRANSP_IDX_DEFAULT = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  // Ceiling log2 usable in parameter expressions.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : log2(n);
  endfunction

endpackage

// File: rtl/fade_ctrl.sv
// Per-frame fade engine and blink phase generator; all state advances on frame_start,
// except fade request capture which happens on any cycle.
module fade_ctrl
  import compositor_pkg::*;
#(
  parameter  int unsigned FADE_STEPS   = 16,
  parameter  int unsigned BLINK_FRAMES = 4,
  localparam int unsigned LVL_W        = log2(FADE_STEPS) + 1,
  localparam int unsigned BC_W         = width_of(BLINK_FRAMES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             fade_out_req,
  input  logic             fade_in_req,
  output logic [LVL_W-1:0] level,
  output logic             blink_phase,
  output logic             fade_busy
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_STEPS);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BLINK_FRAMES - 1);

  fade_state_t      state, state_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             out_pend, out_pend_nxt;
  logic             in_pend, in_pend_nxt;
  logic [BC_W-1:0]  blink_cnt, blink_cnt_nxt;
  logic             blink_phase_nxt;
  logic             fade_busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      level       <= LVL_MAX;
      out_pend    <= 1'b0;
      in_pend     <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      fade_busy   <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      out_pend    <= out_pend_nxt;
      in_pend     <= in_pend_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      fade_busy   <= fade_busy_nxt;
    end
  end

  // Pending bits only live in the state that can honour them; others drop requests.
  always_comb begin
    state_nxt       = state;
    level_nxt       = level;
    out_pend_nxt    = 1'b0;
    in_pend_nxt     = 1'b0;
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    fade_busy_nxt   = 1'b0;

    case (state)
      IDLE: begin
        out_pend_nxt = out_pend | fade_out_req;
        if (frame_start && out_pend_nxt) begin
          state_nxt    = FADE_OUT;
          level_nxt    = level - LVL_ONE;
          out_pend_nxt = 1'b0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          level_nxt = level - LVL_ONE;
          if (level == LVL_ONE) state_nxt = DARK;
        end
      end
      DARK: begin
        in_pend_nxt = in_pend | fade_in_req;
        if (frame_start && in_pend_nxt) begin
          state_nxt   = FADE_IN;
          level_nxt   = level + LVL_ONE;
          in_pend_nxt = 1'b0;
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          level_nxt = level + LVL_ONE;
          if (level == (LVL_MAX - LVL_ONE)) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        level_nxt = LVL_MAX;
      end
    endcase

    if (frame_start) begin
      if (blink_cnt == BC_LAST) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt = blink_cnt + BC_W'(1);
      end
    end

    fade_busy_nxt = (state_nxt == FADE_OUT) || (state_nxt == FADE_IN);
  end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage pixel compositor: priority layer select, palette lookup, fade scaling.
// Pipeline never stalls; pix_valid just rides alongside the data.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter  int unsigned     N_LAYERS     = 8,
  parameter  int unsigned     IDX_W        = 4,
  parameter  int unsigned     N_BANKS      = 4,
  parameter  int unsigned     TRANSP_IDX   = TRANSP_IDX_DEFAULT,
  parameter  logic [RGB_W-1:0] BG_RGB      = 24'h000000,
  parameter  int unsigned     FADE_STEPS   = 16,
  parameter  int unsigned     BLINK_FRAMES = 4,
  localparam int unsigned     BW           = width_of(N_BANKS),
  localparam int unsigned     PAL_AW       = BW + IDX_W
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      pix_valid,
  input  logic                      frame_start,
  input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*BW-1:0]    layer_bank,
  input  logic [N_LAYERS-1:0]       blink_mask,
  input  logic                      pal_we,
  input  logic [PAL_AW-1:0]         pal_addr,
  input  logic [RGB_W-1:0]          pal_data,
  input  logic                      fade_out_req,
  input  logic                      fade_in_req,
  output logic                      fade_busy,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      out_valid
);

  localparam int unsigned PAL_DEPTH = N_BANKS << IDX_W;
  localparam int unsigned SHIFT     = log2(FADE_STEPS);
  localparam int unsigned LVL_W     = SHIFT + 1;
  localparam int unsigned PROD_W    = 8 + LVL_W;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_STEPS);

  logic [LVL_W-1:0] level;
  logic             blink_phase;

  fade_ctrl #(
    .FADE_STEPS   (FADE_STEPS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fade_ctrl (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .frame_start  (frame_start),
    .fade_out_req (fade_out_req),
    .fade_in_req  (fade_in_req),
    .level        (level),
    .blink_phase  (blink_phase),
    .fade_busy    (fade_busy)
  );

  // ---------------- S1: priority select ----------------
  logic             sel_hit;
  logic [BW-1:0]    sel_bank;
  logic [IDX_W-1:0] sel_idx;
  logic             s1_valid, s1_hit;
  logic [BW-1:0]    s1_bank;
  logic [IDX_W-1:0] s1_idx;

  // Walk from lowest priority upward so layer 0 overwrites last.
  always_comb begin
    sel_hit  = 1'b0;
    sel_bank = '0;
    sel_idx  = '0;
    for (int k = int'(N_LAYERS) - 1; k >= 0; k--) begin
      if (layer_en[k] &&
          (layer_idx[k*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX)) &&
          !(blink_mask[k] && blink_phase)) begin
        sel_hit  = 1'b1;
        sel_bank = layer_bank[k*BW +: BW];
        sel_idx  = layer_idx[k*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_bank  <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= sel_hit;
      s1_bank  <= sel_bank;
      s1_idx   <= sel_idx;
    end
  end

  // ---------------- Palette ----------------
  rgb_t pal [PAL_DEPTH];
  logic wr_bank_ok;
  logic rd_bank_ok;

  if (N_BANKS == (1 << BW)) begin : g_full_banks
    assign wr_bank_ok = 1'b1;
    assign rd_bank_ok = 1'b1;
  end else begin : g_part_banks
    assign wr_bank_ok = (pal_addr[PAL_AW-1 -: BW] < BW'(N_BANKS));
    assign rd_bank_ok = (s1_bank < BW'(N_BANKS));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) pal[i] <= '0;
    end else if (pal_we && wr_bank_ok) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // ---------------- S2: palette lookup ----------------
  rgb_t lut_rgb;
  logic s2_valid;
  rgb_t s2_rgb;

  // Unpopulated banks read as black rather than background.
  always_comb begin
    lut_rgb = BG_RGB;
    if (s1_hit) lut_rgb = rd_bank_ok ? pal[{s1_bank, s1_idx}] : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_rgb   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_rgb   <= lut_rgb;
    end
  end

  // ---------------- S3: fade scaling ----------------
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [LVL_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    return (lvl == LVL_MAX) ? c : 8'(prod >> SHIFT);
  endfunction

  rgb_t faded_rgb;

  always_comb begin
    faded_rgb.r = scale_ch(s2_rgb.r, level);
    faded_rgb.g = scale_ch(s2_rgb.g, level);
    faded_rgb.b = scale_ch(s2_rgb.b, level);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      out_valid <= 1'b0;
    end else begin
      VGA_R     <= faded_rgb.r;
      VGA_G     <= faded_rgb.g;
      VGA_B     <= faded_rgb.b;
      out_valid <= s2_valid;
    end
  end

endmodule
